carregador_matriz: RTL

CARREGADOR_MATRIZ -- requirements
Module: carregador_matriz

---
 rtl/carregador_matriz.sv | 94 +++++++++
 1 files changed

// File: rtl/carregador_matriz.sv
// rtl/carregador_matriz.sv - serial 5x5 signed matrix loader with latched scalar for the multiplier stage
module carregador_matriz #(
  parameter int N_ELEM = 25,
  parameter int W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [W-1:0]        num_in,
  input  logic signed [W-1:0]        elem_in,
  input  logic                       elem_valid,
  output logic                       elem_ready,
  input  logic                       matriz_ack,
  output logic signed [N_ELEM*W-1:0] matriz_A,
  output logic signed [W-1:0]        num_inteiro,
  output logic                       matriz_valid,
  output logic [4:0]                 count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of the final element of a load; accepting it completes the matrix.
  localparam logic [4:0] LAST_IDX = 5'(N_ELEM - 1);

  state_t state;

  // Single FSM: elem_ready / matriz_valid are registered state decodes, so no
  // input ever reaches them combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      matriz_A     <= '0;
      num_inteiro  <= '0;
      count        <= '0;
      elem_ready   <= 1'b0;
      matriz_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LOAD;
            num_inteiro  <= num_in;
            matriz_A     <= '0;
            count        <= '0;
            elem_ready   <= 1'b1;
            matriz_valid <= 1'b0;
          end
        end

        LOAD: begin
          if (start) begin
            // Restart wins over a simultaneous element; that element is dropped.
            num_inteiro <= num_in;
            matriz_A    <= '0;
            count       <= '0;
          end else if (elem_valid) begin
            // Write only the slot addressed by count; all other slots keep their value.
            for (int i = 0; i < N_ELEM; i++) begin
              if (count == 5'(i)) begin
                matriz_A[i*W +: W] <= elem_in;
              end
            end
            count <= count + 5'd1;
            if (count == LAST_IDX) begin
              state        <= DONE;
              elem_ready   <= 1'b0;
              matriz_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          // Matrix and scalar stay on the bus after release; only count clears.
          if (matriz_ack) begin
            state        <= IDLE;
            count        <= '0;
            matriz_valid <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          elem_ready   <= 1'b0;
          matriz_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
